// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and small helpers for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter8_onehot8_to_bin3.sv
// Combinational one-hot to binary index encoder; an all-zero input maps to 3'b111.
module onehot8_to_bin3
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] bin
);

    always_comb begin
        bin = 3'b111;
        case (onehot)
            8'h01:   bin = 3'd0;
            8'h02:   bin = 3'd1;
            8'h04:   bin = 3'd2;
            8'h08:   bin = 3'd3;
            8'h10:   bin = 3'd4;
            8'h20:   bin = 3'd5;
            8'h40:   bin = 3'd6;
            8'h80:   bin = 3'd7;
            default: bin = 3'b111;
        endcase
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with done/withdraw release and a hold-time limit.
// Handshake: a requester holds req[n] high until it is granted; the grant stays until done, req drop or timeout.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout_err,
    output logic [1:0]       state_dbg
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);

    arb_state_e        state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              cur_req;
    logic              hold_limit;
    logic              release_now;

    // Search from ptr upward; the 3-bit candidate index wraps 7 -> 0 on its own.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign cur_req     = req[gnt_idx];
    assign hold_limit  = (hold_cnt == HOLD_LAST);
    assign release_now = done || !cur_req || hold_limit;
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            gnt         <= '0;
            gnt_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    hold_cnt <= '0;
                    if (win_found) begin
                        state     <= GRANT;
                        gnt       <= idx_to_onehot(win_idx);
                        gnt_valid <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= RELEASE;
                        gnt         <= '0;
                        gnt_valid   <= 1'b0;
                        hold_cnt    <= '0;
                        ptr         <= gnt_idx + 3'd1;
                        // done or a dropped request on the limit cycle is an ordinary release.
                        timeout_err <= hold_limit && !done && cur_req;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

    onehot8_to_bin3 u_enc (
        .onehot (gnt),
        .bin    (gnt_idx)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (TIMEOUT=4): per-scenario tasks with an expected-value queue.
module tb_rr_arbiter8;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout_err;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    // Packed as {gnt, gnt_idx, gnt_valid, timeout_err}.
    logic [12:0] exp_q[$];
    logic [12:0] got;
    logic [12:0] exp_w;

    always #5 clk = ~clk;

    rr_arbiter8 #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    function automatic logic [12:0] exp_word(input logic [7:0] g, input logic err);
        logic [2:0] idx;
        idx = 3'b111;
        for (int i = 0; i < 8; i++)
            if (g[i]) idx = 3'(i);
        return {g, idx, (g != 8'h00), err};
    endfunction

    task automatic apply_reset();
        req  = 8'h00;
        done = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, step past the edge.
    task automatic drive(input logic [7:0] r, input logic d, input logic [7:0] eg, input logic ee);
        req  = r;
        done = d;
        exp_q.push_back(exp_word(eg, ee));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(gnt) > 1) begin
                failures++;
                $display("FAIL onehot gnt=%h required at most one bit set", gnt);
            end
        end
    end

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_word(8'h00, 1'b0));
        got   = {gnt, gnt_idx, gnt_valid, timeout_err};
        exp_w = exp_q.pop_front();
        checks++;
        if (got !== exp_w || state_dbg !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold got=%h state=%0d required=%h state=0", got, state_dbg, exp_w);
        end
        req = 8'h00;
        rst = 1'b0;
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        got   = {gnt, gnt_idx, gnt_valid, timeout_err};
        exp_w = exp_q.pop_front();
        checks++;
        if (got !== exp_w) begin
            failures++;
            $display("FAIL reset_idle got=%h required=%h", got, exp_w);
        end
    endtask

    task automatic test_single();
        logic [7:0] r_t [7] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
        logic       d_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] g_t [7] = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(r_t[i], d_t[i], g_t[i], 1'b0);
            got   = {gnt, gnt_idx, gnt_valid, timeout_err};
            exp_w = exp_q.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL single step%0d got=%h required=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_rotation();
        logic [7:0] eg;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            eg = (i % 2 == 0) ? (8'h01 << ((i / 2) % 8)) : 8'h00;
            drive(8'hFF, 1'b1, eg, 1'b0);
            got   = {gnt, gnt_idx, gnt_valid, timeout_err};
            exp_w = exp_q.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL rotation step%0d got=%h required=%h", i, got, exp_w);
            end
        end
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        void'(exp_q.pop_front());
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        void'(exp_q.pop_front());
    endtask

    task automatic test_wrap();
        logic [7:0] r_t [5] = '{8'h40, 8'h41, 8'h41, 8'h00, 8'h00};
        logic       d_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] g_t [5] = '{8'h40, 8'h00, 8'h01, 8'h00, 8'h00};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(r_t[i], d_t[i], g_t[i], 1'b0);
            got   = {gnt, gnt_idx, gnt_valid, timeout_err};
            exp_w = exp_q.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL wrap step%0d got=%h required=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] r_t [16] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
                                 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
        logic       d_t [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] g_t [16] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h10, 8'h10,
                                 8'h10, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};
        logic       e_t [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive(r_t[i], d_t[i], g_t[i], e_t[i]);
            got   = {gnt, gnt_idx, gnt_valid, timeout_err};
            exp_w = exp_q.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL timeout step%0d got=%h required=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_withdraw();
        logic [7:0] r_t [6] = '{8'h08, 8'h0C, 8'h04, 8'h04, 8'h00, 8'h00};
        logic [7:0] g_t [6] = '{8'h08, 8'h08, 8'h00, 8'h04, 8'h00, 8'h00};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(r_t[i], 1'b0, g_t[i], 1'b0);
            got   = {gnt, gnt_idx, gnt_valid, timeout_err};
            exp_w = exp_q.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL withdraw step%0d got=%h required=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(8'h80, 1'b0, 8'h80, 1'b0);
            got   = {gnt, gnt_idx, gnt_valid, timeout_err};
            exp_w = exp_q.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL async_pre step%0d got=%h required=%h", i, got, exp_w);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        exp_q.push_back(exp_word(8'h00, 1'b0));
        got   = {gnt, gnt_idx, gnt_valid, timeout_err};
        exp_w = exp_q.pop_front();
        checks++;
        if (got !== exp_w) begin
            failures++;
            $display("FAIL async_clear got=%h required=%h", got, exp_w);
        end
        req = 8'h81;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(8'h81, 1'b0, 8'h01, 1'b0);
        got   = {gnt, gnt_idx, gnt_valid, timeout_err};
        exp_w = exp_q.pop_front();
        checks++;
        if (got !== exp_w) begin
            failures++;
            $display("FAIL async_regrant got=%h required=%h", got, exp_w);
        end
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        got   = {gnt, gnt_idx, gnt_valid, timeout_err};
        exp_w = exp_q.pop_front();
        checks++;
        if (got !== exp_w) begin
            failures++;
            $display("FAIL async_release got=%h required=%h", got, exp_w);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_withdraw();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached before end of tests");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: the maximum number of cycles a grant is held before forced release (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits: request lines; bit n is requester n.
REQ-005 The block SHALL have port done, input, 1 bit: the current grantee releases the resource.
REQ-006 The block SHALL have port gnt, output, 8 bits: grant vector, one-hot or zero.
REQ-007 The block SHALL have port gnt_idx, output, 3 bits: binary index of the granted requester.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit: a grant is active.
REQ-009 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT and RELEASE; all outputs SHALL be registered.
REQ-011 In IDLE or RELEASE with req!=0, the next state SHALL be GRANT, with gnt = one-hot of the first set req bit searching ptr, ptr+1, ... mod 8 (one-cycle latency from req to gnt).
REQ-012 In IDLE or RELEASE with req==0, the next state SHALL be IDLE, with gnt=0 and gnt_valid=0.
REQ-013 In GRANT, gnt, gnt_idx and gnt_valid SHALL stay stable while req[gnt_idx]=1, done=0 and the hold count is below TIMEOUT-1.
REQ-014 The hold count SHALL be 0 on the first GRANT cycle and increment by 1 each GRANT cycle; 4 bits; it SHALL never wrap.
REQ-015 Release SHALL occur when done=1, OR req[gnt_idx]=0, OR the hold count = TIMEOUT-1; on release:
- next state is RELEASE
- gnt=0, gnt_valid=0
- ptr = (gnt_idx+1) mod 8, wrapping 7 -> 0
REQ-016 timeout_err SHALL pulse high for the RELEASE cycle only when the release was caused solely by the hold-count limit; done=1 on the limit cycle SHALL count as a normal release.
REQ-017 When gnt_valid=1, gnt_idx SHALL equal the bit position of gnt (bit0->000 ... bit7->111); when gnt_valid=0, gnt_idx SHALL be 3'b111.
REQ-018 Requests arriving during GRANT SHALL be ignored until RELEASE; a newly raised req bit SHALL have no effect on the current grantee.
REQ-019 The winner SHALL be re-evaluated from the live req value in every IDLE/RELEASE cycle; requests SHALL not be latched.
REQ-020 With a single persistent requester n, the block SHALL re-grant n after each one-cycle RELEASE gap.
REQ-021 gnt SHALL never have more than one bit set.

Reset
REQ-022 While rst=1, the block SHALL hold state=IDLE, gnt=8'h00, gnt_valid=0, gnt_idx=3'b111, timeout_err=0, ptr=0 and hold count=0.
REQ-023 Assertion of rst mid-grant SHALL clear gnt immediately, without waiting for clk.
REQ-024 After rst deasserts, the first arbitration SHALL search from requester 0.

Structure
REQ-025 The shared package SHALL hold N_REQ=8, IDX_W=3, the state encodings (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10) and the hold-count width 4.
REQ-026 The one-hot-to-binary conversion SHALL be a sub-module named onehot8_to_bin3: combinational, default output 3'b111, instantiated on the gnt register.
REQ-027 The rotating priority search SHALL live in the arbiter itself, not in a sub-module.

Verification
REQ-028 The bench SHALL cover a single requester: rst, then req=8'h04 held, done pulsed on the 3rd grant cycle -> gnt=8'h04 and gnt_idx=2 one cycle after req, gnt=0 the cycle after done, re-grant one cycle later.
REQ-029 The bench SHALL cover rotation: req=8'hFF held, done=1 each GRANT cycle -> grants 0,1,2,...,7,0 in order, separated by RELEASE gaps.
REQ-030 The bench SHALL cover wrap priority: grant to 6, then req=8'h41 -> the next grant is 0 (ptr=7, search 7->0).
REQ-031 The bench SHALL cover timeout: TIMEOUT=4, req=8'h10 held, done=0 -> gnt held exactly 4 cycles, then timeout_err=1 for 1 cycle, then gnt=8'h10 again.
REQ-032 The bench SHALL cover requester withdrawal: grant to 3, req[3] dropped -> gnt=0 next cycle and timeout_err=0.
REQ-033 The bench SHALL cover async reset mid-grant: rst asserted between clock edges -> gnt=0 and gnt_idx=3'b111 immediately; after release with req=8'h81, grant goes to 0.
